compressed_serializer: RTL and testbench
========================================

Name: compressed_serializer

Overview:
Downstream stage of the compressor top level. On a rising edge of Done it snapshots the parallel compArray/controlWord result and streams it out one byte per transfer in LZRW1 group order: a 16-bit control word, low byte first, then the group's 16 item bytes. The output uses a valid/ready handshake toward the output buffer or host interface, so the compressor core can be rearmed while the stream drains.

Parameters:
STRINGSIZE, 400, number of compArray entries and controlWord bits (must match compressor; >=1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
Done  input  1  level from compressor; result valid while high
compArray  input  STRINGSIZE x 8  compressed item bytes, entry 0 first
controlWord  input  STRINGSIZE  bit i = control flag for entry i
out_byte  output  8  current stream byte
out_valid  output  1  out_byte is valid
out_ready  input  1  consumer accepts out_byte this cycle
out_last  output  1  final byte of stream, qualified by out_valid
busy  output  1  snapshot held, stream in progress
finished  output  1  whole stream transferred

Behaviour:
- Derived: G = ceil(STRINGSIZE/16) groups; R = STRINGSIZE - 16*(G-1) bytes in the last group (1..16); total bytes = 2*G + STRINGSIZE (450 at default).
- Reset (async, any state): out_byte=0, out_valid=0, out_last=0, busy=0, finished=0, FSM=IDLE, counters=0, done-edge register=0. Reset mid-stream aborts; no resume.
- Done edge: registered copy done_q; start = Done & ~done_q, evaluated only in IDLE.
- FSM IDLE: on start, latch compArray/controlWord into shadow registers, group=0, idx=0, go CTRL_LO. busy=1 and out_valid=1 in the next cycle (latency 1 from the sampled edge).
- CTRL_LO: out_byte = ctrl bits [16g+7:16g]. CTRL_HI: out_byte = bits [16g+15:16g+8]. In the last group, bits beyond STRINGSIZE-1 read as 0.
- DATA: out_byte = compArray[16g+idx]; idx counts 0..15, or 0..R-1 in the last group. Group end goes to CTRL_LO of g+1; last group end goes to FIN.
- Advance only on a transfer (out_valid & out_ready). No bubbles: the next byte is valid in the cycle after a transfer.
- out_valid low with out_ready high: no effect. out_valid high with out_ready low: out_byte, out_last, and state are held stable.
- out_last=1 only while presenting the final DATA byte of the last group.
- FIN: out_valid=0, busy=0, finished=1. Hold until Done is sampled low, then go IDLE with finished=0. Done staying high never retriggers.
- Done rising again while busy: ignored. The shadow registers are unaffected by input changes after the latch.
- Outputs are registered. out_valid is never asserted in IDLE or FIN.

Test Plan:
- STRINGSIZE=400, compArray[i]=i mod 256, controlWord=0, out_ready=1, pulse Done -> out_valid 1 cycle later; 450 bytes: 00,00,00..0F,00,00,10..1F,...; out_last on byte 450 (value 0x8F); finished=1.
- STRINGSIZE=20, controlWord bit0=1 and bit17=1, compArray[i]=0xA0+i -> 24 bytes: 01,00,A0..AF,02,00,B0..B3; out_last on 0xB3.
- Backpressure, STRINGSIZE=20: out_ready toggles every cycle plus a 5-cycle low stall mid-group -> identical 24-byte sequence, no drops or duplicates, out_byte stable across stalls.
- Done held high 1000 cycles -> exactly one stream; finished stays 1 until Done low, then 0; a new Done edge restarts the stream.
- compArray changed right after the latch -> the stream carries the old snapshot values.
- Reset asserted at byte 10 -> out_valid/busy drop immediately; after release a new Done edge restarts from the group-0 control low byte.

Source files
------------

// File: rtl/compressed_serializer.sv
// compressed_serializer: snapshots a finished compressor result and streams it as
// LZRW1 groups (control word low/high byte, then up to 16 item bytes) over valid/ready.
module compressed_serializer #(
    parameter int STRINGSIZE = 400
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       Done,
    input  logic [STRINGSIZE-1:0][7:0] compArray,
    input  logic [STRINGSIZE-1:0]      controlWord,
    output logic [7:0]                 out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       finished
);
    localparam int G  = (STRINGSIZE + 15) / 16;
    localparam int R  = STRINGSIZE - 16 * (G - 1);
    localparam int GW = G > 1 ? $clog2(G) : 1;
    localparam int PW = STRINGSIZE > 1 ? $clog2(STRINGSIZE) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(G - 1);
    localparam logic [3:0]    LAST_R = 4'(R - 1);

    typedef enum logic [2:0] {IDLE, CTRL_LO, CTRL_HI, DATA, FIN} state_t;

    state_t                       state;
    logic                         done_q;
    logic [GW-1:0]                grp;
    logic [3:0]                   idx;
    logic [PW-1:0]                pos;
    logic [STRINGSIZE-1:0][7:0]   comp_s;
    logic [STRINGSIZE-1:0]        ctrl_s;
    logic [G-1:0][15:0]           ctrl_w;
    logic [7:0]                   ctrl_in0;
    logic                         start, xfer, last_grp, grp_end;
    logic [PW-1:0]                pos_n;
    logic [GW-1:0]                grp_n;
    logic [3:0]                   idx_n;

    // control bits past the last entry read as zero
    assign ctrl_w   = (G * 16)'(ctrl_s);
    assign ctrl_in0 = 8'(controlWord);
    assign start    = Done & ~done_q;
    assign xfer     = out_valid & out_ready;
    assign last_grp = grp == LAST_G;
    assign grp_end  = idx == 4'd15 || (last_grp && idx == LAST_R);
    assign pos_n    = pos + PW'(1);
    assign grp_n    = grp + GW'(1);
    assign idx_n    = idx + 4'd1;

    always_ff @(posedge clock)
        if (state == IDLE && start) begin
            comp_s <= compArray;
            ctrl_s <= controlWord;
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            grp       <= '0;
            idx       <= '0;
            pos       <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            done_q <= Done;
            case (state)
                IDLE: if (start) begin
                    state     <= CTRL_LO;
                    grp       <= '0;
                    idx       <= '0;
                    pos       <= '0;
                    out_byte  <= ctrl_in0;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                end
                CTRL_LO: if (xfer) begin
                    state    <= CTRL_HI;
                    out_byte <= ctrl_w[grp][15:8];
                end
                CTRL_HI: if (xfer) begin
                    state    <= DATA;
                    idx      <= '0;
                    out_byte <= comp_s[pos];
                    out_last <= last_grp && LAST_R == 4'd0;
                end
                DATA: if (xfer) begin
                    pos <= pos_n;
                    idx <= idx_n;
                    if (!grp_end) begin
                        out_byte <= comp_s[pos_n];
                        out_last <= last_grp && idx_n == LAST_R;
                    end else if (last_grp) begin
                        state     <= FIN;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                    end else begin
                        state    <= CTRL_LO;
                        grp      <= grp_n;
                        out_byte <= ctrl_w[grp_n][7:0];
                        out_last <= 1'b0;
                    end
                end
                FIN: if (!Done) begin
                    state    <= IDLE;
                    finished <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_compressed_serializer.sv
// tb_compressed_serializer: directed scoreboard bench for the LZRW1 group stream
// on a 20-entry instance and a default 400-entry instance.
module tb_compressed_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             done20 = 1'b0, rdy20 = 1'b1;
    logic [19:0][7:0] comp20;
    logic [19:0]      ctrl20;
    logic [7:0]       ob20;
    logic             ov20, ol20, bz20, fin20;

    logic              done4 = 1'b0, rdy4 = 1'b1;
    logic [399:0][7:0] comp4;
    logic [399:0]      ctrl4;
    logic [7:0]        ob4;
    logic              ov4, ol4, bz4, fin4;

    compressed_serializer #(.STRINGSIZE(20)) u20 (
        .clock(clk), .reset(rst), .Done(done20), .compArray(comp20), .controlWord(ctrl20),
        .out_byte(ob20), .out_valid(ov20), .out_ready(rdy20), .out_last(ol20),
        .busy(bz20), .finished(fin20));

    compressed_serializer u400 (
        .clock(clk), .reset(rst), .Done(done4), .compArray(comp4), .controlWord(ctrl4),
        .out_byte(ob4), .out_valid(ov4), .out_ready(rdy4), .out_last(ol4),
        .busy(bz4), .finished(fin4));

    int passed = 0, total = 0, xfers20 = 0;
    logic [8:0] q20[$], q4[$];
    logic [8:0] e20, e4;
    logic       stall20 = 1'b0;
    logic [7:0] held20;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // expected stream for the 20-entry instance: {last, byte} per transfer
    task automatic push20(input logic [19:0][7:0] c, input logic [19:0] w);
        logic [31:0] wp;
        wp = {12'b0, w};
        for (int g = 0; g < 2; g++) begin
            q20.push_back({1'b0, wp[16*g +: 8]});
            q20.push_back({1'b0, wp[16*g+8 +: 8]});
            for (int k = 0; k < 16; k++)
                if (16*g + k < 20) q20.push_back({16*g + k == 19, c[16*g + k]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse20();
        done20 = 1'b1;
        step();
        chk("latency_valid20", ov20, 1);
        chk("latency_busy20", bz20, 1);
        done20 = 1'b0;
    endtask

    task automatic wait_fin20(input int bound);
        int n;
        n = 0;
        while (!fin20 && n < bound) begin
            step();
            n++;
        end
        chk("fin20", fin20, 1);
        chk("busy_low20", bz20, 0);
        chk("valid_low20", ov20, 0);
        chk("queue_drained20", q20.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) stall20 = 1'b0;
        else begin
            if (stall20 && ov20) chk("stable20", ob20, held20);
            stall20 = ov20 && !rdy20;
            held20  = ob20;
            if (ov20 && rdy20) begin
                if (q20.size() == 0) chk("unexpected_xfer20", ov20, 0);
                else begin
                    e20 = q20.pop_front();
                    chk("byte20", ob20, e20[7:0]);
                    chk("last20", ol20, e20[8]);
                    xfers20++;
                end
            end
        end
    end

    always @(negedge clk)
        if (!rst && ov4 && rdy4) begin
            if (q4.size() == 0) chk("unexpected_xfer400", ov4, 0);
            else begin
                e4 = q4.pop_front();
                chk("byte400", ob4, e4[7:0]);
                chk("last400", ol4, e4[8]);
            end
        end

    initial begin
        int n, base;
        for (int i = 0; i < 20; i++) comp20[i] = 8'(8'hA0 + i);
        ctrl20 = 20'h20001;
        for (int i = 0; i < 400; i++) comp4[i] = 8'(i);
        ctrl4 = '0;
        repeat (3) step();
        chk("rst_byte", ob20, 0);
        chk("rst_valid", ov20, 0);
        chk("rst_last", ol20, 0);
        chk("rst_busy", bz20, 0);
        chk("rst_fin", fin20, 0);
        chk("rst_valid400", ov4, 0);
        rst = 1'b0;
        step();

        // full default-size stream
        for (int g = 0; g < 25; g++) begin
            q4.push_back(9'h000);
            q4.push_back(9'h000);
            for (int k = 0; k < 16; k++)
                q4.push_back({16*g + k == 399, 8'(16*g + k)});
        end
        done4 = 1'b1;
        step();
        chk("latency_valid400", ov4, 1);
        chk("first_byte400", ob4, 0);
        done4 = 1'b0;
        n = 0;
        while (!fin4 && n < 1000) begin
            step();
            n++;
        end
        chk("fin400", fin4, 1);
        chk("busy_low400", bz4, 0);
        chk("queue_drained400", q4.size(), 0);

        // basic 20-entry stream with a partial last group
        push20(comp20, ctrl20);
        pulse20();
        wait_fin20(200);
        step();
        chk("fin_clear20", fin20, 0);

        // backpressure: alternating ready plus a 5-cycle stall mid-group
        push20(comp20, ctrl20);
        pulse20();
        n = 0;
        while (!fin20 && n < 500) begin
            rdy20 = (n >= 20 && n < 25) ? 1'b0 : n[0];
            step();
            n++;
        end
        rdy20 = 1'b1;
        wait_fin20(10);

        // Done held high: one stream only, finished holds until Done drops
        step();
        push20(comp20, ctrl20);
        done20 = 1'b1;
        step();
        chk("held_latency20", ov20, 1);
        wait_fin20(200);
        for (int i = 0; i < 1000; i++) begin
            step();
            if (i % 100 == 99) begin
                chk("held_fin20", fin20, 1);
                chk("held_novalid20", ov20, 0);
            end
        end
        done20 = 1'b0;
        step();
        chk("fin_drop20", fin20, 0);
        push20(comp20, ctrl20);
        pulse20();
        wait_fin20(200);
        step();

        // snapshot isolation: inputs change right after the latch
        for (int i = 0; i < 20; i++) comp20[i] = 8'(8'h40 + 3 * i);
        ctrl20 = 20'h8F0F3;
        push20(comp20, ctrl20);
        done20 = 1'b1;
        step();
        done20 = 1'b0;
        for (int i = 0; i < 20; i++) comp20[i] = 8'hEE;
        ctrl20 = 20'hFFFFF;
        wait_fin20(200);
        step();

        // reset mid-stream aborts; a fresh edge restarts from the group-0 control byte
        for (int i = 0; i < 20; i++) comp20[i] = 8'(8'h30 + i);
        ctrl20 = 20'h0ABCD;
        push20(comp20, ctrl20);
        base = xfers20;
        pulse20();
        n = 0;
        while (xfers20 < base + 10 && n < 200) begin
            step();
            n++;
        end
        chk("reached_byte10", xfers20, base + 10);
        rst = 1'b1;
        #1;
        chk("abort_valid20", ov20, 0);
        chk("abort_busy20", bz20, 0);
        chk("abort_byte20", ob20, 0);
        q20.delete();
        step();
        rst = 1'b0;
        step();
        push20(comp20, ctrl20);
        pulse20();
        chk("restart_byte20", ob20, 8'hCD);
        wait_fin20(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
